// File: rtl/armleocpu_mem_responder_pkg.sv
// Shared encodings and helpers for the memory-side burst responder.
package armleocpu_mem_responder_pkg;

  localparam int unsigned ADDR_W = 34;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BC_W   = 4;
  localparam int unsigned WAIT_W = 4;

  localparam logic [1:0] MEMRSP_IDLE  = 2'd0;
  localparam logic [1:0] MEMRSP_STALL = 2'd1;
  localparam logic [1:0] MEMRSP_READ  = 2'd2;
  localparam logic [1:0] MEMRSP_WRITE = 2'd3;

  localparam logic [DATA_W-1:0] MEMRSP_OOR_READDATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = MEMRSP_IDLE,
    ST_STALL = MEMRSP_STALL,
    ST_READ  = MEMRSP_READ,
    ST_WRITE = MEMRSP_WRITE
  } memrsp_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } memrsp_wbeat_t;

  // A burstcount of zero is served as a single beat.
  function automatic logic [BC_W-1:0] burst_beats(input logic [BC_W-1:0] bc);
    return (bc == '0) ? BC_W'(1) : bc;
  endfunction

endpackage

// File: rtl/armleocpu_mem_responder_ram.sv
// Single-port word RAM: registered read (holds when not read), byte-lane writes, no reset.
module armleocpu_mem_responder_ram
  import armleocpu_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [BE_W-1:0]       be_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/armleocpu_mem_responder.sv
// Avalon-MM style burst slave backing an on-chip RAM: command stalls, read/write bursts,
// window check and sticky error.
module armleocpu_mem_responder
  import armleocpu_mem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2  = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 34'h0,
  parameter int unsigned       WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [BC_W-1:0]   s_burstcount,
  output logic              s_waitrequest,
  input  logic              s_read,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic [BE_W-1:0]   s_byteenable,
  output logic              err
);

  localparam int unsigned       TAG_LSB   = DEPTH_LOG2 + 2;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  memrsp_state_e         state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [BC_W-1:0]       left_q, left_d;
  logic                  oor_q, oor_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rsel_q, rsel_d;
  logic                  err_q, err_d;

  logic                  waitreq_c;
  logic                  accept_c;
  logic                  ram_re_c;
  logic                  ram_we_c;
  logic [DEPTH_LOG2-1:0] ram_addr_c;
  logic [DATA_W-1:0]     ram_rdata;
  memrsp_wbeat_t         wbeat;

  logic [DEPTH_LOG2-1:0] cmd_word;
  logic                  cmd_oor;
  logic [BC_W-1:0]       cmd_beats;
  logic                  unused_addr_lsb;

  // Window is aligned to its size, so the check is a tag compare of the upper bits.
  assign cmd_word        = s_address[TAG_LSB-1:2];
  assign cmd_oor         = s_address[ADDR_W-1:TAG_LSB] != BASE_ADDR[ADDR_W-1:TAG_LSB];
  assign cmd_beats       = burst_beats(s_burstcount);
  assign unused_addr_lsb = ^s_address[1:0];
  assign wbeat           = '{data: s_writedata, be: s_byteenable};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      left_q   <= '0;
      oor_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      left_q   <= left_d;
      oor_q    <= oor_d;
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    left_d     = left_q;
    oor_d      = oor_q;
    rvalid_d   = 1'b0;
    rsel_d     = rsel_q;
    err_d      = err_q;
    waitreq_c  = 1'b1;
    accept_c   = 1'b0;
    ram_re_c   = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr_c = ptr_q;

    case (state_q)
      ST_IDLE: begin
        waitreq_c = (WAIT_CYCLES != 0);
        if (s_read || s_write) begin
          if (WAIT_CYCLES == 0) begin
            accept_c = 1'b1;
          end else begin
            state_d = ST_STALL;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_STALL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          waitreq_c = 1'b0;
          if (s_read || s_write) accept_c = 1'b1;
          else                   state_d  = ST_IDLE;
        end
      end
      ST_READ: begin
        if (left_q != '0) begin
          ram_re_c = !oor_q;
          rsel_d   = !oor_q;
          rvalid_d = 1'b1;
          ptr_d    = ptr_q + DEPTH_LOG2'(1);
          left_d   = left_q - BC_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        waitreq_c = 1'b0;
        if (s_read) err_d = 1'b1;
        if (s_write) begin
          ram_we_c = !oor_q;
          ptr_d    = ptr_q + DEPTH_LOG2'(1);
          left_d   = left_q - BC_W'(1);
          if (left_q == BC_W'(1)) state_d = ST_IDLE;
        end
      end
    endcase

    // Accepting a command serves its first beat in the same cycle; write wins a collision.
    if (accept_c) begin
      ram_addr_c = cmd_word;
      oor_d      = cmd_oor;
      ptr_d      = cmd_word + DEPTH_LOG2'(1);
      left_d     = cmd_beats - BC_W'(1);
      if (cmd_oor || (s_read && s_write)) err_d = 1'b1;
      if (s_write) begin
        ram_we_c = !cmd_oor;
        state_d  = (cmd_beats == BC_W'(1)) ? ST_IDLE : ST_WRITE;
      end else begin
        ram_re_c = !cmd_oor;
        rsel_d   = !cmd_oor;
        rvalid_d = 1'b1;
        state_d  = ST_READ;
      end
    end
  end

  armleocpu_mem_responder_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .re_i   (ram_re_c),
    .we_i   (ram_we_c),
    .addr_i (ram_addr_c),
    .wdata_i(wbeat.data),
    .be_i   (wbeat.be),
    .rdata_o(ram_rdata)
  );

  // RAM read register holds between reads; out-of-window beats select the fixed pattern.
  assign s_readdata      = rsel_q ? ram_rdata : MEMRSP_OOR_READDATA;
  assign s_readdatavalid = rvalid_q;
  assign s_waitrequest   = waitreq_c | !rst_n;
  assign err             = err_q;

endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// Scoreboard bench for armleocpu_mem_responder: a no-stall 4K-word instance and a
// 3-stall 16-word instance sharing clock and reset.
module tb_armleocpu_mem_responder;

  localparam int DL_A = 12;
  localparam int DL_B = 4;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] addr  [2];
  logic [3:0]  bc    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        waitreq [2];
  logic        rvalid  [2];
  logic        err     [2];
  logic [31:0] rdata   [2];

  logic [31:0] mem_m [2][4096];
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  armleocpu_mem_responder #(.DEPTH_LOG2(DL_A), .BASE_ADDR(34'h0), .WAIT_CYCLES(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_address(addr[0]), .s_burstcount(bc[0]),
    .s_waitrequest(waitreq[0]), .s_read(rd[0]), .s_readdata(rdata[0]),
    .s_readdatavalid(rvalid[0]), .s_write(wr[0]), .s_writedata(wdata[0]),
    .s_byteenable(be[0]), .err(err[0])
  );

  armleocpu_mem_responder #(.DEPTH_LOG2(DL_B), .BASE_ADDR(34'h0), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_address(addr[1]), .s_burstcount(bc[1]),
    .s_waitrequest(waitreq[1]), .s_read(rd[1]), .s_readdata(rdata[1]),
    .s_readdatavalid(rvalid[1]), .s_write(wr[1]), .s_writedata(wdata[1]),
    .s_byteenable(be[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int dl(input int sel);
    return (sel == 0) ? DL_A : DL_B;
  endfunction

  function automatic bit in_win(input int sel, input logic [33:0] a);
    return (a >> (dl(sel) + 2)) == 34'h0;
  endfunction

  function automatic int word_idx(input int sel, input logic [33:0] a, input int i);
    return (int'(a >> 2) + i) & ((1 << dl(sel)) - 1);
  endfunction

  // Scoreboard monitors: every valid beat must match data and arrival cycle.
  always @(negedge clk) begin
    if (rvalid[0] === 1'b1) begin
      if (q0.size() == 0) chk("a_rd_extra", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("a_rd_data", rdata[0], e0.data);
        chk("a_rd_cyc", cyc, e0.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid[1] === 1'b1) begin
      if (q1.size() == 0) chk("b_rd_extra", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("b_rd_data", rdata[1], e1.data);
        chk("b_rd_cyc", cyc, e1.cyc);
      end
    end
  end

  task automatic do_write(input int sel, input logic [33:0] a, input int n,
                          input logic [31:0] d0, input logic [3:0] ben,
                          input bit rd_too, input int stalls_exp);
    int st, idx, nb;
    nb = (n == 0) ? 1 : n;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      addr[sel] = a; bc[sel] = 4'(n); wr[sel] = 1'b1; rd[sel] = rd_too && (i == 0);
      wdata[sel] = d0 + 32'(i); be[sel] = ben;
      st = 0;
      @(negedge clk);
      while (waitreq[sel] && st < 20) begin st++; @(negedge clk); end
      chk(sel == 0 ? "a_wr_stall" : "b_wr_stall", st, (i == 0) ? stalls_exp : 0);
      if (in_win(sel, a)) begin
        idx = word_idx(sel, a, i);
        for (int j = 0; j < 4; j++)
          if (ben[j]) mem_m[sel][idx][8*j +: 8] = wdata[sel][8*j +: 8];
      end
      @(posedge clk); #1;
    end
    wr[sel] = 1'b0; rd[sel] = 1'b0;
  endtask

  task automatic do_read(input int sel, input logic [33:0] a, input int n, input int stalls_exp);
    int st, nb, t;
    exp_t e;
    nb = (n == 0) ? 1 : n;
    @(posedge clk); #1;
    addr[sel] = a; bc[sel] = 4'(n); rd[sel] = 1'b1;
    st = 0;
    @(negedge clk);
    while (waitreq[sel] && st < 20) begin st++; @(negedge clk); end
    chk(sel == 0 ? "a_rd_stall" : "b_rd_stall", st, stalls_exp);
    t = cyc;
    for (int i = 0; i < nb; i++) begin
      e.data = in_win(sel, a) ? mem_m[sel][word_idx(sel, a, i)] : 32'h0;
      e.cyc  = t + 1 + i;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(posedge clk); #1;
    rd[sel] = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    int k;
    k = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && k < 40) begin
      @(negedge clk); #1; k++;
    end
    chk(sel == 0 ? "a_drain" : "b_drain", (sel == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; bc[s] = '0; rd[s] = 1'b0; wr[s] = 1'b0; wdata[s] = '0; be[s] = '0;
    end
    #2;
    chk("a_rst_rvalid", rvalid[0], 0);
    chk("a_rst_rdata", rdata[0], 0);
    chk("a_rst_err", err[0], 0);
    chk("a_rst_wait", waitreq[0], 1);
    chk("b_rst_rvalid", rvalid[1], 0);
    chk("b_rst_wait", waitreq[1], 1);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("a_idle_wait", waitreq[0], 0);
    chk("b_idle_wait", waitreq[1], 1);

    // Basic burst write/read, byte lanes, zero byteenable, zero burstcount
    do_write(0, 34'h40, 4, 32'h1, 4'hF, 0, 0);
    do_read(0, 34'h40, 4, 0); wait_drain(0);
    do_write(0, 34'h50, 4, 32'h5, 4'hF, 0, 0);
    do_write(0, 34'h0, 1, 32'hFFFF_FFFF, 4'hF, 0, 0);
    do_write(0, 34'h0, 1, 32'h1122_3344, 4'b0101, 0, 0);
    do_write(0, 34'h4, 1, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_write(0, 34'h4, 1, 32'h1234_5678, 4'h0, 0, 0);
    do_read(0, 34'h0, 2, 0); wait_drain(0);
    do_read(0, 34'h44, 0, 0); wait_drain(0);
    chk("a_err_clean", err[0], 0);

    // Out-of-window read and write; word 0 is the alias a bad decode would hit
    do_read(0, 34'h4000, 2, 0); wait_drain(0);
    chk("a_oor_err", err[0], 1);
    do_write(0, 34'h4000, 1, 32'hCAFE_F00D, 4'hF, 0, 0);
    do_read(0, 34'h0, 1, 0); wait_drain(0);

    // Stalled instance: wrap-around burst, then read+write collision
    do_write(1, 34'h38, 4, 32'hA0, 4'hF, 0, 3);
    do_read(1, 34'h38, 4, 3); wait_drain(1);
    chk("b_wrap_err", err[1], 0);
    do_write(1, 34'h8, 1, 32'h55, 4'hF, 1, 3);
    chk("b_coll_err", err[1], 1);
    do_read(1, 34'h8, 1, 3); wait_drain(1);

    // Reset after the third beat of an 8-beat burst
    do_read(0, 34'h40, 8, 0);
    k = 0;
    while (q0.size() > 5 && k < 30) begin @(negedge clk); #1; k++; end
    chk("a_mid_beats_left", q0.size(), 5);
    rst_n = 1'b0; #1;
    chk("a_mid_rst_rvalid", rvalid[0], 0);
    chk("a_mid_rst_err", err[0], 0);
    chk("a_mid_rst_wait", waitreq[0], 1);
    chk("a_mid_rst_rdata", rdata[0], 0);
    q0.delete();
    @(negedge clk); #1;
    chk("a_mid_rst_quiet", rvalid[0], 0);
    rst_n = 1'b1;
    do_read(0, 34'h40, 8, 0); wait_drain(0);
    chk("b_post_rst_err", err[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
